// File: rtl/mips32r2_tlb_op_ctrl.sv
// Sequences one CP0 TLB instruction (TLBR/TLBWI/TLBWR/TLBP) onto a group-rotating TLB
// and owns the CP0 Random counter. Optional multi-hit detection: MIPS32R2_TLB_MULTIHIT_EN.
module mips32r2_tlb_op_ctrl #(
  parameter int unsigned ENTRIES    = 64,
  parameter int unsigned GROUP_SIZE = 4,
  parameter int unsigned EntryW     = 80,  // width of the packed TLBEntry
  localparam int unsigned IW        = $clog2(ENTRIES)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic [1:0]        req_op_i,
  input  logic [IW-1:0]     req_index_i,
  input  logic [EntryW-1:0] req_entry_i,
  input  logic [18:0]       req_vpn2_i,
  input  logic [7:0]        req_asid_i,
  input  logic [IW-1:0]     wired_i,
  input  logic              wired_we_i,
  output logic [IW-1:0]     random_o,
  output logic [IW-1:0]     tlb_r_index_o,
  input  logic              tlb_r_ready_i,
  input  logic [EntryW-1:0] tlb_r_resp_i,
  output logic              tlb_w_valid_o,
  output logic [IW-1:0]     tlb_w_index_o,
  output logic [EntryW-1:0] tlb_w_data_o,
  input  logic              tlb_w_ready_i,
  output logic [18:0]       tlb_p_ivpn2_o,
  output logic [7:0]        tlb_p_iasid_o,
  input  logic              tlb_p_ready_i,
  input  logic [IW-1:0]     tlb_p_index_i,
  output logic              resp_valid_o,
  output logic [1:0]        resp_op_o,
  output logic [IW-1:0]     resp_index_o,
  output logic [EntryW-1:0] resp_entry_o,
  output logic              resp_probe_miss_o
`ifdef MIPS32R2_TLB_MULTIHIT_EN
  ,
  output logic              resp_multihit_o
`endif
);

  localparam int unsigned NG = ENTRIES / GROUP_SIZE;
  localparam int unsigned SW = $clog2(NG) + 1;
  localparam logic [IW-1:0] IdxMax   = IW'(ENTRIES - 1);
  localparam logic [SW-1:0] ScntLast = SW'(NG - 1);

  localparam logic [1:0] OpTlbr  = 2'd0;
  localparam logic [1:0] OpTlbwi = 2'd1;
  localparam logic [1:0] OpTlbwr = 2'd2;

  typedef enum logic [2:0] {StIdle, StRead, StWrite, StProbe, StResp} state_e;

  state_e              state_q, state_d;
  logic [IW-1:0]       random_q, random_d;
  logic [IW-1:0]       r_index_q, r_index_d;
  logic                w_valid_q, w_valid_d;
  logic [IW-1:0]       w_index_q, w_index_d;
  logic [EntryW-1:0]   w_data_q, w_data_d;
  logic [18:0]         p_ivpn2_q, p_ivpn2_d;
  logic [7:0]          p_iasid_q, p_iasid_d;
  logic [SW-1:0]       scnt_q, scnt_d;
  logic                resp_valid_q, resp_valid_d;
  logic [1:0]          resp_op_q, resp_op_d;
  logic [IW-1:0]       resp_index_q, resp_index_d;
  logic [EntryW-1:0]   resp_entry_q, resp_entry_d;
  logic                resp_miss_q, resp_miss_d;
`ifdef MIPS32R2_TLB_MULTIHIT_EN
  logic [1:0]          hit_cnt_q, hit_cnt_d;  // saturates at 2
  logic                multihit_q, multihit_d;
`endif

  // Random walks down from ENTRIES-1 to Wired, then wraps.
  always_comb begin
    random_d = random_q - IW'(1);
    if (wired_we_i || (wired_i == IdxMax) || (random_q <= wired_i)) begin
      random_d = IdxMax;
    end
  end

  always_comb begin
    state_d      = state_q;
    r_index_d    = r_index_q;
    w_valid_d    = w_valid_q;
    w_index_d    = w_index_q;
    w_data_d     = w_data_q;
    p_ivpn2_d    = p_ivpn2_q;
    p_iasid_d    = p_iasid_q;
    scnt_d       = scnt_q;
    resp_valid_d = 1'b0;
    resp_op_d    = resp_op_q;
    resp_index_d = resp_index_q;
    resp_entry_d = resp_entry_q;
    resp_miss_d  = resp_miss_q;
`ifdef MIPS32R2_TLB_MULTIHIT_EN
    hit_cnt_d    = hit_cnt_q;
    multihit_d   = multihit_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (req_valid_i) begin
          scnt_d       = '0;
          resp_op_d    = req_op_i;
          resp_index_d = '0;
          resp_entry_d = '0;
          resp_miss_d  = 1'b0;
`ifdef MIPS32R2_TLB_MULTIHIT_EN
          hit_cnt_d    = 2'd0;
          multihit_d   = 1'b0;
`endif
          unique case (req_op_i)
            OpTlbr: begin
              r_index_d    = req_index_i;
              resp_index_d = req_index_i;
              state_d      = StRead;
            end
            OpTlbwi, OpTlbwr: begin
              // TLBWR takes the pre-update Random of this very cycle.
              w_index_d    = (req_op_i == OpTlbwr) ? random_q : req_index_i;
              resp_index_d = (req_op_i == OpTlbwr) ? random_q : req_index_i;
              w_data_d     = req_entry_i;
              w_valid_d    = 1'b1;
              state_d      = StWrite;
            end
            default: begin
              p_ivpn2_d = req_vpn2_i;
              p_iasid_d = req_asid_i;
              state_d   = StProbe;
            end
          endcase
        end
      end
      StRead: begin
        if (tlb_r_ready_i) begin
          resp_entry_d = tlb_r_resp_i;
          resp_valid_d = 1'b1;
          state_d      = StResp;
        end
      end
      StWrite: begin
        if (tlb_w_ready_i) begin
          w_valid_d    = 1'b0;
          resp_valid_d = 1'b1;
          state_d      = StResp;
        end
      end
      StProbe: begin
        scnt_d = scnt_q + SW'(1);
`ifdef MIPS32R2_TLB_MULTIHIT_EN
        if (tlb_p_ready_i) begin
          if (hit_cnt_q == 2'd0) resp_index_d = tlb_p_index_i;
          if (hit_cnt_q != 2'd2) hit_cnt_d = hit_cnt_q + 2'd1;
        end
        if (scnt_q == ScntLast) begin
          resp_valid_d = 1'b1;
          state_d      = StResp;
          multihit_d   = (hit_cnt_d == 2'd2);
          if (hit_cnt_d == 2'd0) begin
            resp_miss_d  = 1'b1;
            resp_index_d = '0;
          end
        end
`else
        if (tlb_p_ready_i) begin
          resp_index_d = tlb_p_index_i;
          resp_miss_d  = 1'b0;
          resp_valid_d = 1'b1;
          state_d      = StResp;
        end else if (scnt_q == ScntLast) begin
          resp_index_d = '0;
          resp_miss_d  = 1'b1;
          resp_valid_d = 1'b1;
          state_d      = StResp;
        end
`endif
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= StIdle;
      random_q     <= IdxMax;
      r_index_q    <= '0;
      w_valid_q    <= 1'b0;
      w_index_q    <= '0;
      w_data_q     <= '0;
      p_ivpn2_q    <= '0;
      p_iasid_q    <= '0;
      scnt_q       <= '0;
      resp_valid_q <= 1'b0;
      resp_op_q    <= '0;
      resp_index_q <= '0;
      resp_entry_q <= '0;
      resp_miss_q  <= 1'b0;
`ifdef MIPS32R2_TLB_MULTIHIT_EN
      hit_cnt_q    <= 2'd0;
      multihit_q   <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      random_q     <= random_d;
      r_index_q    <= r_index_d;
      w_valid_q    <= w_valid_d;
      w_index_q    <= w_index_d;
      w_data_q     <= w_data_d;
      p_ivpn2_q    <= p_ivpn2_d;
      p_iasid_q    <= p_iasid_d;
      scnt_q       <= scnt_d;
      resp_valid_q <= resp_valid_d;
      resp_op_q    <= resp_op_d;
      resp_index_q <= resp_index_d;
      resp_entry_q <= resp_entry_d;
      resp_miss_q  <= resp_miss_d;
`ifdef MIPS32R2_TLB_MULTIHIT_EN
      hit_cnt_q    <= hit_cnt_d;
      multihit_q   <= multihit_d;
`endif
    end
  end

  assign req_ready_o       = (state_q == StIdle);
  assign random_o          = random_q;
  assign tlb_r_index_o     = r_index_q;
  assign tlb_w_valid_o     = w_valid_q;
  assign tlb_w_index_o     = w_index_q;
  assign tlb_w_data_o      = w_data_q;
  assign tlb_p_ivpn2_o     = p_ivpn2_q;
  assign tlb_p_iasid_o     = p_iasid_q;
  assign resp_valid_o      = resp_valid_q;
  assign resp_op_o         = resp_op_q;
  assign resp_index_o      = resp_index_q;
  assign resp_entry_o      = resp_entry_q;
  assign resp_probe_miss_o = resp_miss_q;
`ifdef MIPS32R2_TLB_MULTIHIT_EN
  assign resp_multihit_o   = multihit_q;
`endif

endmodule

// File: tb/tb_mips32r2_tlb_op_ctrl.sv
// Scoreboard bench for mips32r2_tlb_op_ctrl: the bench plays the TLB and CP0, a reference
// model predicts every response/write, and a monitor checks what the DUT presents.
module tb_mips32r2_tlb_op_ctrl;
  localparam int ENTRIES = 64;
  localparam int GS      = 4;
  localparam int NG      = ENTRIES / GS;
  localparam int IW      = 6;
  localparam int EW      = 80;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          req_valid = 0, req_ready;
  logic [1:0]    req_op = 0;
  logic [IW-1:0] req_index = 0;
  logic [EW-1:0] req_entry = 0;
  logic [18:0]   req_vpn2 = 0;
  logic [7:0]    req_asid = 0;
  logic [IW-1:0] wired = 0, rnd_dut;
  logic          wired_we = 0;
  logic [IW-1:0] tlb_r_index, tlb_w_index, tlb_p_index = 0;
  logic          tlb_r_ready = 0, tlb_w_ready = 0, tlb_p_ready = 0, tlb_w_valid;
  logic [EW-1:0] tlb_r_resp = 0, tlb_w_data;
  logic [18:0]   tlb_p_ivpn2;
  logic [7:0]    tlb_p_iasid;
  logic          resp_valid, resp_miss, resp_mh;
  logic [1:0]    resp_op;
  logic [IW-1:0] resp_index;
  logic [EW-1:0] resp_entry;

  mips32r2_tlb_op_ctrl #(.ENTRIES(ENTRIES), .GROUP_SIZE(GS), .EntryW(EW)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_op_i(req_op),
    .req_index_i(req_index), .req_entry_i(req_entry), .req_vpn2_i(req_vpn2),
    .req_asid_i(req_asid), .wired_i(wired), .wired_we_i(wired_we), .random_o(rnd_dut),
    .tlb_r_index_o(tlb_r_index), .tlb_r_ready_i(tlb_r_ready), .tlb_r_resp_i(tlb_r_resp),
    .tlb_w_valid_o(tlb_w_valid), .tlb_w_index_o(tlb_w_index), .tlb_w_data_o(tlb_w_data),
    .tlb_w_ready_i(tlb_w_ready), .tlb_p_ivpn2_o(tlb_p_ivpn2), .tlb_p_iasid_o(tlb_p_iasid),
    .tlb_p_ready_i(tlb_p_ready), .tlb_p_index_i(tlb_p_index),
    .resp_valid_o(resp_valid), .resp_op_o(resp_op), .resp_index_o(resp_index),
    .resp_entry_o(resp_entry), .resp_probe_miss_o(resp_miss)
`ifdef MIPS32R2_TLB_MULTIHIT_EN
    , .resp_multihit_o(resp_mh)
`endif
  );
`ifndef MIPS32R2_TLB_MULTIHIT_EN
  assign resp_mh = 1'b0;
`endif

  typedef struct {
    logic [1:0] op; logic [IW-1:0] idx; logic [EW-1:0] entry; logic miss; logic mh; int cyc;
  } exp_t;
  typedef struct { logic [IW-1:0] idx; logic [EW-1:0] data; } wexp_t;

  exp_t  sq[$];
  wexp_t wq[$];
  int total = 0, bad = 0, cyc = 0;
  logic [EW-1:0] ref_mem[ENTRIES];
  logic [EW-1:0] tlb_mem[ENTRIES];
  logic [18:0]   pv2[ENTRIES];
  logic [7:0]    pas[ENTRIES];
  int            rnd_m = ENTRIES - 1;

  always @(posedge clk) cyc <= cyc + 1;

  // CP0 Random reference: counts down to Wired, wraps to the top, pinned while Wired is max.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) rnd_m <= ENTRIES - 1;
    else if (wired_we || int'(wired) >= ENTRIES - 1 || rnd_m == int'(wired)) rnd_m <= ENTRIES - 1;
    else rnd_m <= rnd_m - 1;
  end

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [EW-1:0] rnd_ent();
    logic [95:0] r;
    r = {$urandom(), $urandom(), $urandom()};
    return r[EW-1:0];
  endfunction

  // Monitor: pops expectations whenever the DUT presents a write or a response.
  initial forever begin
    exp_t e;
    wexp_t w;
    @(negedge clk);
    if (rst_n) begin
      chk("random", rnd_dut, rnd_m[IW-1:0]);
      if (tlb_w_valid && tlb_w_ready) begin
        tlb_mem[tlb_w_index] = tlb_w_data;
        if (wq.size() == 0) chk("spurious_write", tlb_w_valid, 0);
        else begin
          w = wq.pop_front();
          chk("w_index", tlb_w_index, w.idx);
          chk("w_data", tlb_w_data, w.data);
        end
      end
      if (resp_valid) begin
        if (sq.size() == 0) chk("spurious_resp", resp_valid, 0);
        else begin
          e = sq.pop_front();
          chk("resp_op", resp_op, e.op);
          chk("resp_index", resp_index, e.idx);
          chk("resp_entry", resp_entry, e.entry);
          chk("resp_probe_miss", resp_miss, e.miss);
          chk("resp_multihit", resp_mh, e.mh);
          chk("resp_cycle", cyc, e.cyc);
        end
      end
    end
  end

  task automatic issue(input int op, input logic [IW-1:0] idx, input logic [EW-1:0] ent,
                       input logic [18:0] v2, input logic [7:0] as, input int d,
                       input int want_rnd, input bit we_pulse, input logic [IW-1:0] we_val);
    exp_t e;
    int n = 0, a, first = -1, groups = 0;
    bit ok;
    do begin
      @(negedge clk);
      n++;
      ok = req_ready && (want_rnd < 0 || rnd_m == want_rnd);
    end while (!ok && n < 300);
    chk("accept_wait", {127'b0, ok}, 1);
    if (!ok) return;
    req_valid = 1; req_op = 2'(op); req_index = idx; req_entry = ent;
    req_vpn2 = v2; req_asid = as;
    if (we_pulse) begin wired = we_val; wired_we = 1; end
    e.op = 2'(op); e.idx = idx; e.entry = '0; e.miss = 0; e.mh = 0;
    case (op)
      0: e.entry = ref_mem[idx];
      1: begin wq.push_back('{idx, ent}); ref_mem[idx] = ent; end
      2: begin
        e.idx = rnd_m[IW-1:0];
        wq.push_back('{e.idx, ent});
        ref_mem[e.idx] = ent;
      end
      default: begin
        for (int g = 0; g < NG; g++) begin
          bit any = 0;
          for (int k = 0; k < GS; k++)
            if (pv2[g*GS+k] == v2 && pas[g*GS+k] == as) begin
              if (first < 0) first = g * GS + k;
              any = 1;
            end
          groups += int'(any);
        end
      end
    endcase
    @(posedge clk); #1;
    req_valid = 0; wired_we = 0;
    a = cyc;
    if (op == 3) begin
`ifdef MIPS32R2_TLB_MULTIHIT_EN
      e.cyc = a + NG;
      e.mh = (groups >= 2);
`else
      e.cyc = (first >= 0) ? a + 1 + first / GS : a + NG;
`endif
      e.miss = (first < 0);
      e.idx = (first < 0) ? '0 : IW'(first);
    end else e.cyc = a + 1 + d;
    sq.push_back(e);
    if (op == 3) begin
      // TLB side: one group per cycle, answering whatever the DUT is driving on the probe port.
      for (int c = 0; c < NG; c++) begin
        tlb_p_ready = 0;
        tlb_p_index = IW'($urandom());
        for (int k = 0; k < GS; k++)
          if (!tlb_p_ready && pv2[c*GS+k] == tlb_p_ivpn2 && pas[c*GS+k] == tlb_p_iasid) begin
            tlb_p_ready = 1;
            tlb_p_index = IW'(c * GS + k);
          end
        @(posedge clk); #1;
      end
      tlb_p_ready = 0;
    end else begin
      for (int i = 0; i <= d; i++) begin
        if (op == 0) begin
          tlb_r_ready = (i == d);
          tlb_r_resp = (i == d) ? tlb_mem[tlb_r_index] : rnd_ent();
        end else tlb_w_ready = (i == d);
        // Requests while busy must be ignored.
        req_valid = 1'($urandom()); req_op = 2'($urandom()); req_index = IW'($urandom());
        #1 chk("busy_not_ready", req_ready, 0);
        @(posedge clk); #1;
      end
      tlb_r_ready = 0; tlb_w_ready = 0; req_valid = 0;
    end
  endtask

  initial begin
    for (int i = 0; i < ENTRIES; i++) begin
      ref_mem[i] = rnd_ent();
      tlb_mem[i] = ref_mem[i];
      pv2[i] = 19'(32'h100 + i * 3);
      pas[i] = 8'(i);
    end
    pv2[22] = 19'h1234; pas[22] = 8'h12;
    pv2[5] = 19'hABCD; pas[5] = 8'h33;
    pv2[50] = 19'hABCD; pas[50] = 8'h33;

    repeat (3) @(negedge clk);
    chk("rst_req_ready", req_ready, 1);
    chk("rst_random", rnd_dut, 63);
    chk("rst_w_valid", tlb_w_valid, 0);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_r_index", tlb_r_index, 0);
    rst_n = 1;

    // Reset in the middle of a write abandons it at once.
    @(negedge clk);
    req_valid = 1; req_op = 1; req_index = 7; req_entry = rnd_ent();
    @(posedge clk); #1 req_valid = 0;
    @(negedge clk); chk("wv_before_rst", tlb_w_valid, 1);
    #2 rst_n = 0;
    #1 chk("rst_mid_w_valid", tlb_w_valid, 0);
    chk("rst_mid_req_ready", req_ready, 1);
    chk("rst_mid_random", rnd_dut, 63);
    @(negedge clk); @(negedge clk) rst_n = 1;

    issue(0, 13, '0, 0, 0, 5, -1, 0, 0);                 // TLBR 13, r_ready 5 cycles later
    issue(1, 40, rnd_ent(), 0, 0, 2, -1, 0, 0);          // TLBWI 40, w_valid held 3 cycles
    issue(0, 40, '0, 0, 0, 0, -1, 0, 0);                 // read back, minimum latency
    issue(3, 0, '0, 19'h1234, 8'h12, 0, -1, 0, 0);       // probe hit at 22
    issue(3, 0, '0, 19'h7FFFF, 8'h12, 0, -1, 0, 0);      // probe miss
    issue(3, 0, '0, 19'hABCD, 8'h33, 0, -1, 0, 0);       // hits at 5 and 50
    issue(0, 0, '0, 0, 0, 1, -1, 1, 60);                 // wired=60 with the acceptance
    repeat (8) @(negedge clk);
    issue(2, 0, rnd_ent(), 0, 0, 1, 61, 0, 0);           // TLBWR at random=61
    issue(2, 0, rnd_ent(), 0, 0, 0, 62, 1, 10);          // wired_we with TLBWR: old random
    issue(2, 0, rnd_ent(), 0, 0, 3, -1, 1, 63);          // wired max pins random
    issue(0, 0, '0, 0, 0, 0, -1, 1, 0);

    for (int t = 0; t < 80; t++) begin
      int op, k;
      logic [18:0] v2;
      logic [7:0] as;
      op = int'($urandom_range(0, 3));
      k = int'($urandom_range(0, ENTRIES - 1));
      if ($urandom_range(0, 1) == 1) begin v2 = pv2[k]; as = pas[k]; end
      else begin v2 = 19'($urandom()); as = 8'($urandom()); end
      issue(op, IW'($urandom()), rnd_ent(), v2, as, int'($urandom_range(0, NG - 1)), -1,
            $urandom_range(0, 5) == 0, IW'($urandom_range(40, 63)));
    end

    for (int n = 0; n < 100 && sq.size() != 0; n++) @(negedge clk);
    @(negedge clk);
    chk("scoreboard_empty", sq.size(), 0);
    chk("writes_empty", wq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mips32r2_tlb_op_ctrl.md
Name: mips32r2_tlb_op_ctrl

Overview:
Initiator-side sequencer for the group-rotating slow TLB, driving its read, write and probe ports on behalf of CP0.
- Accepts one TLB instruction at a time from the pipeline: TLBR, TLBWI, TLBWR or TLBP.
- Holds that request on the TLB ports until the TLB signals ready, or until a full group rotation has passed.
- Returns a single-cycle response carrying the index, read entry and probe result.
- Owns the CP0 Random counter used by TLBWR.

Parameters:
ENTRIES, 64, number of TLB entries; power of two.
GROUP_SIZE, 4, entries per TLB group; must match the TLB instance.
IW, $clog2(ENTRIES), index width (derived; not overridden).

Ports:
clock  in  1  system clock
reset_n  in  1  asynchronous active-low reset
req_valid  in  1  TLB op request
req_ready  out  1  high only in IDLE
req_op  in  2  0=TLBR 1=TLBWI 2=TLBWR 3=TLBP
req_index  in  IW  CP0 Index (TLBR/TLBWI)
req_entry  in  TLBEntry  write data (TLBWI/TLBWR)
req_vpn2  in  19  EntryHi.VPN2 (TLBP)
req_asid  in  8  EntryHi.ASID (TLBP)
wired  in  IW  CP0 Wired value
wired_we  in  1  Wired written this cycle
random  out  IW  CP0 Random value
tlb_r_index  out  IW  to TLB r_index
tlb_r_ready  in  1  from TLB
tlb_r_resp  in  TLBEntry  from TLB
tlb_w_valid  out  1  to TLB
tlb_w_index  out  IW  to TLB
tlb_w_data  out  TLBEntry  to TLB
tlb_w_ready  in  1  from TLB
tlb_p_ivpn2  out  19  probe port 0 VPN2
tlb_p_iasid  out  8  probe port 0 ASID
tlb_p_ready  in  1  probe port 0 hit
tlb_p_index  in  IW  probe port 0 hit index
resp_valid  out  1  one-cycle completion pulse
resp_op  out  2  op that completed
resp_index  out  IW  index read, written or probed
resp_entry  out  TLBEntry  TLBR data, else 0
resp_probe_miss  out  1  TLBP missed (Index.P)

Behaviour:
Reset (async, reset_n low):
- Enter IDLE immediately.
- Drive all outputs to 0, with two exceptions: req_ready=1 and random=ENTRIES-1.
- tlb_w_valid drops combinationally with reset, so a write in flight is abandoned.
- Release is synchronous to clock.

State machine: IDLE, READ, WRITE, PROBE, RESP. All TLB-port outputs are registered.

IDLE:
- Accept on req_valid && req_ready.
- Latch all operands:
  - TLBR: tlb_r_index=req_index.
  - TLBWI: w_index=req_index.
  - TLBWR: w_index=random, sampled in the acceptance cycle.
  - TLBP: p_ivpn2/p_iasid from req_vpn2/req_asid.
- Go to READ, WRITE or PROBE next cycle.
- Clear scan counter scnt.

READ: wait for tlb_r_ready. In that cycle capture tlb_r_resp into resp_entry, then go to RESP.

WRITE:
- Assert tlb_w_valid and hold w_index/w_data stable.
- On a cycle with tlb_w_ready=1, deassert w_valid the next cycle and go to RESP.
- Exactly one write is committed.

PROBE:
- scnt counts cycles spent in PROBE (width $clog2(ENTRIES/GROUP_SIZE)+1).
- Cycle with tlb_p_ready=1: capture tlb_p_index into resp_index, set resp_probe_miss=0, go to RESP.
- Cycle with scnt==ENTRIES/GROUP_SIZE-1 and no hit: resp_probe_miss=1, resp_index=0, go to RESP.
- Worst-case probe latency is ENTRIES/GROUP_SIZE cycles in PROBE.

READ and WRITE have no timeout. The TLB guarantees ready within ENTRIES/GROUP_SIZE cycles.

RESP:
- resp_valid=1 for exactly one cycle.
- resp_* hold until the next acceptance.
- Go to IDLE.
- Minimum accept-to-resp_valid latency is 2 cycles.

Random counter (always running, all states):
- If wired_we, the next value is ENTRIES-1.
- Else if wired >= ENTRIES-1, hold at ENTRIES-1.
- Else if random == wired, wrap to ENTRIES-1.
- Else decrement by 1.
- random is never below wired (when wired <= ENTRIES-1) and never above ENTRIES-1.
- A TLBWR uses the pre-update value from the acceptance cycle.

Simultaneous events:
- wired_we in the same cycle as TLBWR acceptance: TLBWR uses the old random value.
- req_valid while not IDLE: ignored; req_ready is 0.

Optional Feature:
Macro: MIPS32R2_TLB_MULTIHIT_EN.
- Defined:
  - PROBE always scans all ENTRIES/GROUP_SIZE cycles and counts cycles with tlb_p_ready.
  - The first hit's index is reported.
  - Extra output resp_multihit (1 bit, reset 0) is set when the hit count is >=2 (machine check).
  - Probe latency is fixed at ENTRIES/GROUP_SIZE cycles.
- Undefined: the probe ends at the first hit, and the port resp_multihit does not exist.

Test Plan:
1. Reset: reset_n low mid-WRITE -> tlb_w_valid=0 immediately, req_ready=1, random=63 after release.
2. TLBR index 13, TLB model asserts r_ready 5 cycles later with entry E -> one resp_valid, resp_entry=E, resp_index=13.
3. TLBWI index 40 data D, w_ready after 3 cycles -> w_valid held 3 cycles, exactly one write of D to 40, then resp_valid.
4. TLBP VPN2 0x1234 present at entry 22 -> resp_probe_miss=0, resp_index=22. Absent -> miss after exactly 16 PROBE cycles, resp_index=0.
5. Random: wired=60 -> sequence 63,62,61,60,63. wired_we pulse -> 63 next cycle. TLBWR accepted when random=61 -> w_index=61.
6. MULTIHIT_EN: VPN2 matches entries 5 and 50 -> resp_index=5, resp_multihit=1, resp after 16 cycles. Without the macro -> resp_index=5, early completion.
